fifo_rd_packer: RTL
===================

// Module: fifo_rd_packer
// PURPOSE
//   Read-side consumer of the async FIFO, running in the FIFO read clock domain.
//   Pops DATA_WIDTH words through the FIFO read port and packs PACK_RATIO words, LSB-first, into one wide beat.
//   Delivers beats on a valid/ready stream and sustains one FIFO read per cycle.
//   A flush request emits a partial beat with a keep mask and a last flag, used for end-of-frame/drain.
// PARAMETERS
//   DATA_WIDTH  8  FIFO word width; must match the FIFO DATA_WIDTH
//   PACK_RATIO  4  FIFO words per output beat, >=2; counters are $clog2(PACK_RATIO+1) bits wide
// PORTS
//   rd_clk        in   1                      clock (the FIFO read clock)
//   rd_rst        in   1                      synchronous, active-high reset
//   fifo_rd_en    out  1                      FIFO read request (combinational)
//   fifo_rd_data  in   DATA_WIDTH             FIFO read data, valid 1 cycle after an accepted read
//   fifo_rd_empty in   1                      FIFO empty flag
//   flush         in   1                      1-cycle pulse: emit the partially packed beat
//   m_valid       out  1                      output beat valid
//   m_ready       in   1                      downstream accepts the beat
//   m_data        out  DATA_WIDTH*PACK_RATIO  packed beat; word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_keep        out  PACK_RATIO             bit i = word i present
//   m_last        out  1                      beat produced by a flush
//   busy          out  1                      flush pending
//   word_cnt      out  $clog2(PACK_RATIO+1)   words held in the assembly register
// BEHAVIOUR
//   Reset: m_valid/m_last/busy/fifo_rd_en=0, m_data/m_keep/word_cnt=0, in-flight read discarded.
//   - Reset must coincide with the FIFO rd_rstn.
//   Read acceptance and capture:
//   - accepted read = fifo_rd_en & !fifo_rd_empty.
//   - inflight = registered accepted read; in that cycle fifo_rd_data is captured into slot word_cnt.
//   State: assembly register + word_cnt (0..PACK_RATIO), inflight bit, flush_pend (=busy), output register.
//   Derived signals:
//   - out_free   = !m_valid | m_ready
//   - beat_ready = (word_cnt==PACK_RATIO) | (inflight & word_cnt==PACK_RATIO-1)
//   - flush_emit = flush_pend & (word_cnt!=0 | inflight)
//   - move       = (beat_ready | flush_emit) & out_free
//   fifo_rd_en = !fifo_rd_empty & !flush_pend & ((word_cnt+inflight < PACK_RATIO) | move).
//   Move edge:
//   - Assembly plus any landing word goes to the output register; m_valid=1.
//   - m_keep = ones for occupied slots.
//   - m_last = flush_emit.
//   - word_cnt -> 0; flush_pend -> 0.
//   - A read issued in the move cycle lands in slot 0 of the next beat.
//   No move, beat complete: the landing word fills slot PACK_RATIO-1 (word_cnt=PACK_RATIO); reads stall until out_free.
//   Output stream:
//   - m_valid & !m_ready: m_data/m_keep/m_last held stable.
//   - m_valid & m_ready & !move: m_valid -> 0.
//   Flush:
//   - flush=1 sets flush_pend at the next edge; a read accepted in the same cycle is included in the flush beat.
//   - flush with word_cnt==0 & !inflight: ignored.
//   - flush while flush_pend=1: merged.
//   - flush_pend with nothing to emit clears next edge without a beat.
//   - Full beat ready with flush_pend: emitted with m_last=1, all keep bits set.
//   Latency / throughput:
//   - First accepted read in cycle 0, reads every cycle: m_valid=1 in cycle PACK_RATIO+1.
//   - Sustained: 1 word/cycle while m_ready=1 and FIFO non-empty.
//   fifo_rd_empty=1: no read is issued; a partial beat is held indefinitely until more data or a flush.
//   No word dropped or duplicated except on reset.
// TESTING
//   1. Reset, FIFO holds 8 words 0x01..0x08, m_ready=1 -> two beats 0x04030201, 0x08070605; keep=4'hF; last=0.
//      First m_valid in cycle 5 after first rd_en.
//   2. Continuous FIFO data, m_ready=1 -> fifo_rd_en high every cycle, one beat per 4 cycles, no bubbles.
//   3. m_ready=0 for 10 cycles with FIFO full -> holds one output beat + 4 assembled words, fifo_rd_en=0.
//      Beat stable; on release, in-order delivery resumes.
//   4. 3 words 0xA1,0xA2,0xA3 then flush -> beat m_data=0x00A3A2A1, m_keep=4'b0111, m_last=1; busy clears.
//   5. flush with empty assembly and no in-flight read -> no beat, busy stays 0.
//      flush in the same cycle as a 4th word's rd_en -> full beat with m_last=1.
//   6. rd_rst asserted mid-beat (2 words held, read in flight) -> next cycle all outputs 0, word_cnt=0.
//      After reset release, the next beat contains only post-reset words.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle between the async-FIFO read port, the packer and the downstream beat stream.
// The packer side (master) drives the FIFO read request and the packed output stream.
interface fifo_rd_packer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4
);
  localparam int unsigned CW = $clog2(PACK_RATIO + 1);

  logic                             fifo_rd_en;
  logic [DATA_WIDTH-1:0]            fifo_rd_data;
  logic                             fifo_rd_empty;
  logic                             flush;
  logic                             m_valid;
  logic                             m_ready;
  logic [DATA_WIDTH*PACK_RATIO-1:0] m_data;
  logic [PACK_RATIO-1:0]            m_keep;
  logic                             m_last;
  logic                             busy;
  logic [CW-1:0]                    word_cnt;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    input  flush,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_keep,
    output m_last,
    output busy,
    output word_cnt
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    output flush,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_keep,
    input  m_last,
    input  busy,
    input  word_cnt
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words one per cycle and packs PACK_RATIO of them LSB-first into a wide valid/ready beat;
// a flush pulse emits the partially packed beat with a keep mask and last flag.
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  fifo_rd_packer_if.master bus
);
  localparam int unsigned   CW        = $clog2(PACK_RATIO + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(PACK_RATIO);
  localparam logic [CW-1:0] LAST_SLOT = CW'(PACK_RATIO - 1);

  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] asm_q, asm_d, asm_full;
  logic [CW-1:0]                         cnt_q, cnt_d, cnt_full, words_after;
  logic                                  inflight_q, inflight_d;
  logic                                  flush_pend_q, flush_pend_d;
  logic                                  m_valid_q, m_valid_d;
  logic                                  m_last_q, m_last_d;
  logic [PACK_RATIO-1:0]                 m_keep_q, m_keep_d, keep_full;
  logic [DATA_WIDTH*PACK_RATIO-1:0]      m_data_q, m_data_d, data_full;
  logic                                  out_free, beat_ready, flush_emit, move, rd_en;

  always_comb begin
    cnt_full   = cnt_q + CW'(inflight_q);
    out_free   = !m_valid_q || bus.m_ready;
    beat_ready = (cnt_q == FULL_CNT) || (inflight_q && (cnt_q == LAST_SLOT));
    flush_emit = flush_pend_q && ((cnt_q != '0) || inflight_q);
    move       = (beat_ready || flush_emit) && out_free;
    rd_en      = !bus.fifo_rd_empty && !flush_pend_q && ((cnt_full < FULL_CNT) || move);

    // Assembly view including the word landing this cycle; unoccupied slots read as zero.
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      asm_full[i]  = (inflight_q && (cnt_q == CW'(i))) ? bus.fifo_rd_data : asm_q[i];
      keep_full[i] = CW'(i) < cnt_full;
      data_full[i*DATA_WIDTH +: DATA_WIDTH] = keep_full[i] ? asm_full[i] : '0;
    end

    // Words owned by the packer after this edge decide whether a flush has anything to emit.
    words_after  = (move ? '0 : cnt_full) + CW'(rd_en);
    flush_pend_d = (bus.flush && (words_after != '0)) || (flush_pend_q && flush_emit && !move);
    inflight_d   = rd_en;

    asm_d     = asm_full;
    cnt_d     = cnt_full;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;

    if (move) begin
      asm_d     = '0;
      cnt_d     = '0;
      m_valid_d = 1'b1;
      m_data_d  = data_full;
      m_keep_d  = keep_full;
      m_last_d  = flush_emit;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      asm_q        <= '0;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_keep     = m_keep_q;
  assign bus.m_last     = m_last_q;
  assign bus.busy       = flush_pend_q;
  assign bus.word_cnt   = cnt_q;
endmodule
